// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of a 5-stage ARM-subset pipeline.
//
// Takes the IF/ID register contents (pc, instruction), decodes the data
// processing, load/store and branch classes, checks the condition field
// against NZCV, reads operands from a 16-entry register file (entry 15 is
// the PC alias) and hands everything to execute through an ID/EX register.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   pc_i, instruction_i      IF/ID register contents
//   status_i                 NZCV flags {N,Z,C,V}
//   hazard_i                 insert a bubble (controls forced to 0)
//   flush_i                  kill the instruction in decode (outputs 0)
//   wb_en_i/wb_dest_i/wb_value_i  register-file writeback port
//   src1_o, src2_o, two_src_o     combinational source indices for hazards
//   pc_o ... s_o             registered ID/EX outputs to execute
module id_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [31:0]       instruction_i,
  input  logic [3:0]        status_i,
  input  logic              hazard_i,
  input  logic              flush_i,
  input  logic              wb_en_i,
  input  logic [3:0]        wb_dest_i,
  input  logic [DATA_W-1:0] wb_value_i,
  output logic [3:0]        src1_o,
  output logic [3:0]        src2_o,
  output logic              two_src_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] val_rn_o,
  output logic [DATA_W-1:0] val_rm_o,
  output logic              imm_o,
  output logic [11:0]       shift_operand_o,
  output logic [23:0]       signed_imm_24_o,
  output logic [3:0]        dest_o,
  output logic [3:0]        exe_cmd_o,
  output logic              mem_r_en_o,
  output logic              mem_w_en_o,
  output logic              wb_en_o,
  output logic              b_o,
  output logic              s_o
);

  localparam logic [3:0] PC_IDX = 4'(REG_CNT - 1);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [3:0]        dest;
    logic [3:0]        exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic              b;
    logic              s;
  } idex_t;

  // Condition-field evaluation against {N,Z,C,V}; 1111 never executes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = !z;
      4'b0010: res = c;
      4'b0011: res = !c;
      4'b0100: res = n;
      4'b0101: res = !n;
      4'b0110: res = v;
      4'b0111: res = !v;
      4'b1000: res = c && !z;
      4'b1001: res = !c || z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = !z && (n == v);
      4'b1101: res = z || (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Entries 0..14 only; entry 15 is served by pc_i.
  logic [DATA_W-1:0] rf_r [0:REG_CNT-2];

  logic [3:0]  cond_s;
  logic [1:0]  mode_s;
  logic        i_bit_s;
  logic [3:0]  opcode_s;
  logic        sl_bit_s;
  logic [3:0]  rn_s;
  logic [3:0]  rd_s;
  logic [3:0]  rm_s;
  logic        store_s;
  logic        bubble_s;

  logic [3:0]  exe_cmd_s;
  logic        mem_r_en_s;
  logic        mem_w_en_s;
  logic        wb_en_s;
  logic        b_s;
  logic        s_s;

  logic [DATA_W-1:0] val_rn_s;
  logic [DATA_W-1:0] val_rm_s;
  idex_t             idex_next_s;
  idex_t             idex_r;

  assign cond_s   = instruction_i[31:28];
  assign mode_s   = instruction_i[27:26];
  assign i_bit_s  = instruction_i[25];
  assign opcode_s = instruction_i[24:21];
  assign sl_bit_s = instruction_i[20];
  assign rn_s     = instruction_i[19:16];
  assign rd_s     = instruction_i[15:12];
  assign rm_s     = instruction_i[3:0];

  assign store_s   = (mode_s == 2'b01) && !sl_bit_s;
  assign src1_o    = rn_s;
  assign src2_o    = store_s ? rd_s : rm_s;
  assign two_src_o = ((mode_s == 2'b00) && !i_bit_s) || store_s;
  assign bubble_s  = !cond_pass(cond_s, status_i) || hazard_i;

  // Control decode by instruction class and opcode.
  always_comb begin
    exe_cmd_s  = 4'b0000;
    mem_r_en_s = 1'b0;
    mem_w_en_s = 1'b0;
    wb_en_s    = 1'b0;
    b_s        = 1'b0;
    s_s        = 1'b0;
    case (mode_s)
      2'b00: begin
        // Unlisted opcodes leave every control (including s) at 0.
        case (opcode_s)
          4'b1101: begin exe_cmd_s = 4'b0001; wb_en_s = 1'b1; s_s = sl_bit_s; end
          4'b1111: begin exe_cmd_s = 4'b1001; wb_en_s = 1'b1; s_s = sl_bit_s; end
          4'b0100: begin exe_cmd_s = 4'b0010; wb_en_s = 1'b1; s_s = sl_bit_s; end
          4'b0101: begin exe_cmd_s = 4'b0011; wb_en_s = 1'b1; s_s = sl_bit_s; end
          4'b0010: begin exe_cmd_s = 4'b0100; wb_en_s = 1'b1; s_s = sl_bit_s; end
          4'b0110: begin exe_cmd_s = 4'b0101; wb_en_s = 1'b1; s_s = sl_bit_s; end
          4'b0000: begin exe_cmd_s = 4'b0110; wb_en_s = 1'b1; s_s = sl_bit_s; end
          4'b1100: begin exe_cmd_s = 4'b0111; wb_en_s = 1'b1; s_s = sl_bit_s; end
          4'b0001: begin exe_cmd_s = 4'b1000; wb_en_s = 1'b1; s_s = sl_bit_s; end
          4'b1010: begin exe_cmd_s = 4'b0100; wb_en_s = 1'b0; s_s = sl_bit_s; end
          4'b1000: begin exe_cmd_s = 4'b0110; wb_en_s = 1'b0; s_s = sl_bit_s; end
          default: begin exe_cmd_s = 4'b0000; wb_en_s = 1'b0; s_s = 1'b0; end
        endcase
      end
      2'b01: begin
        exe_cmd_s = 4'b0010;
        if (sl_bit_s) begin
          mem_r_en_s = 1'b1;
          wb_en_s    = 1'b1;
        end else begin
          mem_w_en_s = 1'b1;
        end
      end
      2'b10: begin
        b_s = 1'b1;
      end
      default: begin
        exe_cmd_s = 4'b0000;
      end
    endcase
  end

  // Operand reads: PC alias for 15, then same-cycle writeback bypass, then array.
  always_comb begin
    if (rn_s == PC_IDX) begin
      val_rn_s = pc_i;
    end else if (wb_en_i && (wb_dest_i == rn_s)) begin
      val_rn_s = wb_value_i;
    end else begin
      val_rn_s = rf_r[rn_s];
    end
    if (src2_o == PC_IDX) begin
      val_rm_s = pc_i;
    end else if (wb_en_i && (wb_dest_i == src2_o)) begin
      val_rm_s = wb_value_i;
    end else begin
      val_rm_s = rf_r[src2_o];
    end
  end

  // ID/EX next value: data fields always load, controls drop to 0 on a bubble.
  always_comb begin
    idex_next_s.pc            = pc_i;
    idex_next_s.val_rn        = val_rn_s;
    idex_next_s.val_rm        = val_rm_s;
    idex_next_s.imm           = i_bit_s;
    idex_next_s.shift_operand = instruction_i[11:0];
    idex_next_s.signed_imm_24 = instruction_i[23:0];
    idex_next_s.dest          = rd_s;
    if (bubble_s) begin
      idex_next_s.exe_cmd  = 4'b0000;
      idex_next_s.mem_r_en = 1'b0;
      idex_next_s.mem_w_en = 1'b0;
      idex_next_s.wb_en    = 1'b0;
      idex_next_s.b        = 1'b0;
      idex_next_s.s        = 1'b0;
    end else begin
      idex_next_s.exe_cmd  = exe_cmd_s;
      idex_next_s.mem_r_en = mem_r_en_s;
      idex_next_s.mem_w_en = mem_w_en_s;
      idex_next_s.wb_en    = wb_en_s;
      idex_next_s.b        = b_s;
      idex_next_s.s        = s_s;
    end
  end

  // Register file: cleared by reset; writes to the PC alias are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT - 1; i++) begin
        rf_r[i] <= '0;
      end
    end else if (wb_en_i && (wb_dest_i != PC_IDX)) begin
      rf_r[wb_dest_i] <= wb_value_i;
    end
  end

  // ID/EX register: reset, then flush (wins over hazard), then load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_r <= '0;
    end else if (flush_i) begin
      idex_r <= '0;
    end else begin
      idex_r <= idex_next_s;
    end
  end

  assign pc_o            = idex_r.pc;
  assign val_rn_o        = idex_r.val_rn;
  assign val_rm_o        = idex_r.val_rm;
  assign imm_o           = idex_r.imm;
  assign shift_operand_o = idex_r.shift_operand;
  assign signed_imm_24_o = idex_r.signed_imm_24;
  assign dest_o          = idex_r.dest;
  assign exe_cmd_o       = idex_r.exe_cmd;
  assign mem_r_en_o      = idex_r.mem_r_en;
  assign mem_w_en_o      = idex_r.mem_w_en;
  assign wb_en_o         = idex_r.wb_en;
  assign b_o             = idex_r.b;
  assign s_o             = idex_r.s;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed, scoreboard-based bench for id_stage.
// Each step drives one instruction, pushes the expected ID/EX contents to a
// queue, clocks once and pops/compares the registered outputs.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic [31:0] instruction_i;
  logic [3:0]  status_i;
  logic        hazard_i;
  logic        flush_i;
  logic        wb_en_i;
  logic [3:0]  wb_dest_i;
  logic [31:0] wb_value_i;
  logic [3:0]  src1_o;
  logic [3:0]  src2_o;
  logic        two_src_o;
  logic [31:0] pc_o;
  logic [31:0] val_rn_o;
  logic [31:0] val_rm_o;
  logic        imm_o;
  logic [11:0] shift_operand_o;
  logic [23:0] signed_imm_24_o;
  logic [3:0]  dest_o;
  logic [3:0]  exe_cmd_o;
  logic        mem_r_en_o;
  logic        mem_w_en_o;
  logic        wb_en_o;
  logic        b_o;
  logic        s_o;

  id_stage #(.DATA_W(32), .REG_CNT(16)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .instruction_i(instruction_i),
    .status_i(status_i), .hazard_i(hazard_i), .flush_i(flush_i),
    .wb_en_i(wb_en_i), .wb_dest_i(wb_dest_i), .wb_value_i(wb_value_i),
    .src1_o(src1_o), .src2_o(src2_o), .two_src_o(two_src_o),
    .pc_o(pc_o), .val_rn_o(val_rn_o), .val_rm_o(val_rm_o), .imm_o(imm_o),
    .shift_operand_o(shift_operand_o), .signed_imm_24_o(signed_imm_24_o),
    .dest_o(dest_o), .exe_cmd_o(exe_cmd_o), .mem_r_en_o(mem_r_en_o),
    .mem_w_en_o(mem_w_en_o), .wb_en_o(wb_en_o), .b_o(b_o), .s_o(s_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, exe;
    logic        mr, mw, wb, b, s;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [31:0] pc, input logic [31:0] instr, input logic [3:0] st,
                     input logic hz, input logic fl, input logic we,
                     input logic [3:0] wd, input logic [31:0] wv);
    pc_i = pc; instruction_i = instr; status_i = st; hazard_i = hz; flush_i = fl;
    wb_en_i = we; wb_dest_i = wd; wb_value_i = wv;
  endtask

  // Expected decoded entry; data fields are the plain instruction slices.
  task automatic push_dec(input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] rn, input logic [31:0] rm, input logic [3:0] exe,
                          input logic mr, input logic mw, input logic wb, input logic b, input logic s);
    exp_t e;
    e.pc = pc; e.rn = rn; e.rm = rm; e.imm = instr[25]; e.sh = instr[11:0];
    e.si = instr[23:0]; e.dest = instr[15:12]; e.exe = exe;
    e.mr = mr; e.mw = mw; e.wb = wb; e.b = b; e.s = s;
    q.push_back(e);
  endtask

  task automatic push_zero();
    exp_t e;
    e.pc = 32'h0; e.rn = 32'h0; e.rm = 32'h0; e.imm = 1'b0; e.sh = 12'h0; e.si = 24'h0;
    e.dest = 4'h0; e.exe = 4'h0; e.mr = 1'b0; e.mw = 1'b0; e.wb = 1'b0; e.b = 1'b0; e.s = 1'b0;
    q.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      total = total + 1;
      failed = failed + 1;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".pc"}, pc_o, e.pc);
      chk({tag, ".rn"}, val_rn_o, e.rn);
      chk({tag, ".rm"}, val_rm_o, e.rm);
      chk({tag, ".imm"}, 32'(imm_o), 32'(e.imm));
      chk({tag, ".shift"}, 32'(shift_operand_o), 32'(e.sh));
      chk({tag, ".simm"}, 32'(signed_imm_24_o), 32'(e.si));
      chk({tag, ".dest"}, 32'(dest_o), 32'(e.dest));
      chk({tag, ".exe"}, 32'(exe_cmd_o), 32'(e.exe));
      chk({tag, ".mr"}, 32'(mem_r_en_o), 32'(e.mr));
      chk({tag, ".mw"}, 32'(mem_w_en_o), 32'(e.mw));
      chk({tag, ".wb"}, 32'(wb_en_o), 32'(e.wb));
      chk({tag, ".b"}, 32'(b_o), 32'(e.b));
      chk({tag, ".s"}, 32'(s_o), 32'(e.s));
    end
  endtask

  logic [8:0]  ctab [10];
  logic [31:0] instr;

  initial begin
    // {cond, nzcv, pass}
    ctab[0] = {4'b1100, 4'b1001, 1'b1};  // GT
    ctab[1] = {4'b1011, 4'b1000, 1'b1};  // LT
    ctab[2] = {4'b1101, 4'b0000, 1'b0};  // LE
    ctab[3] = {4'b1000, 4'b0010, 1'b1};  // HI
    ctab[4] = {4'b1001, 4'b0010, 1'b0};  // LS
    ctab[5] = {4'b1111, 4'b1111, 1'b0};  // never
    ctab[6] = {4'b0100, 4'b1000, 1'b1};  // MI
    ctab[7] = {4'b0111, 4'b0001, 1'b0};  // VC
    ctab[8] = {4'b1010, 4'b1001, 1'b1};  // GE
    ctab[9] = {4'b0001, 4'b0100, 1'b0};  // NE

    // Reset for two cycles; a writeback during reset must not land.
    rst = 1'b0;
    drv(32'h44, 32'hE083_1003, 4'h0, 1'b0, 1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF);
    push_zero(); step("reset0");
    push_zero(); step("reset1");
    rst = 1'b1;

    // R0..R14 read back as zero.
    for (int i = 0; i < 15; i++) begin
      instr = 32'hE080_1000 | (32'(i) << 16) | 32'(i);
      drv(32'h100 + 32'(i), instr, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      #1;
      chk("rdzero.src1", 32'(src1_o), 32'(i));
      push_dec(32'h100 + 32'(i), instr, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("rdzero");
    end

    // Writeback with same-cycle bypass, then the stored value.
    drv(32'h200, 32'hE083_1003, 4'h0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h0000_00AA);
    push_dec(32'h200, 32'hE083_1003, 32'hAA, 32'hAA, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("bypass");
    drv(32'h204, 32'hE083_1003, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h204, 32'hE083_1003, 32'hAA, 32'hAA, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("stored");

    // ADDEQ: fails with Z=0, executes with Z=1.
    drv(32'h208, 32'h0083_1003, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h208, 32'h0083_1003, 32'hAA, 32'hAA, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("addeq_fail");
    drv(32'h20C, 32'h0083_1003, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h20C, 32'h0083_1003, 32'hAA, 32'hAA, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("addeq_pass");

    // Condition table on MOV R2,R3.
    for (int k = 0; k < 10; k++) begin
      instr = {ctab[k][8:5], 28'h1A0_2003};
      drv(32'h300 + 32'(k), instr, ctab[k][4:1], 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      if (ctab[k][0])
        push_dec(32'h300 + 32'(k), instr, 32'h0, 32'hAA, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      else
        push_dec(32'h300 + 32'(k), instr, 32'h0, 32'hAA, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("cond");
    end

    // STR R2,[R5] with R2 written in the same cycle; then LDR.
    drv(32'h400, 32'hE585_2000, 4'h0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h1234_5678);
    #1;
    chk("str.src1", 32'(src1_o), 32'd5);
    chk("str.src2", 32'(src2_o), 32'd2);
    chk("str.two_src", 32'(two_src_o), 32'd1);
    push_dec(32'h400, 32'hE585_2000, 32'h0, 32'h1234_5678, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("str");
    drv(32'h404, 32'hE595_2000, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    #1;
    chk("ldr.src2", 32'(src2_o), 32'd0);
    chk("ldr.two_src", 32'(two_src_o), 32'd0);
    push_dec(32'h404, 32'hE595_2000, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("ldr");

    // SUBS R4,R3,R1: normal, with hazard, with hazard and flush.
    drv(32'h500, 32'hE053_4001, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h500, 32'hE053_4001, 32'hAA, 32'h0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("subs");
    drv(32'h504, 32'hE053_4001, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h504, 32'hE053_4001, 32'hAA, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hazard");
    drv(32'h508, 32'hE053_4001, 4'h0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
    push_zero(); step("hazard_flush");

    // Flush still lets the register-file write happen.
    drv(32'h50C, 32'hE053_4001, 4'h0, 1'b0, 1'b1, 1'b1, 4'd6, 32'h55);
    push_zero(); step("flush");
    drv(32'h510, 32'hE086_7006, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h510, 32'hE086_7006, 32'h55, 32'h55, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("flush_wb");

    // Branch.
    drv(32'h600, 32'hEA00_0004, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h600, 32'hEA00_0004, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("branch");

    // R15: write ignored, reads return pc_i.
    drv(32'h10, 32'hE1A0_000F, 4'h0, 1'b0, 1'b0, 1'b1, 4'd15, 32'hFFFF_FFFF);
    push_dec(32'h10, 32'hE1A0_000F, 32'h0, 32'h10, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mov_pc");
    drv(32'h20, 32'hE08F_100F, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h20, 32'hE08F_100F, 32'h20, 32'h20, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("add_pc");

    // Undefined DP opcode (RSBS): every control 0, s included.
    drv(32'h700, 32'hE073_1003, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h700, 32'hE073_1003, 32'hAA, 32'hAA, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("undef");

    // Immediate ADD: single source.
    drv(32'h704, 32'hE283_1005, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    #1;
    chk("addi.two_src", 32'(two_src_o), 32'd0);
    push_dec(32'h704, 32'hE283_1005, 32'hAA, 32'h0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("addi");

    // CMP: flags only.
    drv(32'h708, 32'hE153_0001, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h708, 32'hE153_0001, 32'hAA, 32'h0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("cmp");

    // Mode 11.
    drv(32'h70C, 32'hEC00_0000, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h70C, 32'hEC00_0000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mode11");

    // Mid-stream reset discards the instruction and clears the registers.
    rst = 1'b0;
    drv(32'h800, 32'hE083_1003, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_zero(); step("midreset");
    rst = 1'b1;
    drv(32'h804, 32'hE083_1003, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    push_dec(32'h804, 32'hE083_1003, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
